// File: rtl/ex_muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encodings and per-op operand sign selection.
package ex_muldiv_pkg;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  function automatic logic rs1_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic rs2_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_sign_fix.sv
// Two independent conditional two's-complement negators; used to take operand
// magnitudes on the way in and to restore result signs on the way out.
module ex_muldiv_sign_fix #(
  parameter int WA = 32,
  parameter int WB = 32
) (
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  input  logic          neg_a,
  input  logic          neg_b,
  output logic [WA-1:0] fix_a,
  output logic [WB-1:0] fix_b
);

  assign fix_a = neg_a ? (~a + WA'(1)) : a;
  assign fix_b = neg_b ? (~b + WB'(1)) : b;

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide for the EX stage: 32-step shift-add multiply,
// 32-step restoring divide, single-cycle fast path for div-by-zero and overflow.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [RD_W-1:0] rd_addr,
  input  logic            flush,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [RD_W-1:0] result_rd_addr
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  md_state_e         state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, acc_nxt;
  logic [XLEN-1:0]   m;
  logic [2:0]        op_q;
  logic              neg_q, neg_r;
  logic [RD_W-1:0]   rd_q;

  logic              s1, s2, accept, div_zero, ovf, fast;
  logic [XLEN-1:0]   mag1, mag2, fast_val, final_val;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [XLEN-1:0]   div_sub;
  logic              div_ge;
  logic [2*XLEN-1:0] corr_a, fix_a;
  logic [XLEN-1:0]   fix_b;

  assign s1     = rs1_val[XLEN-1] & rs1_signed(op);
  assign s2     = rs2_val[XLEN-1] & rs2_signed(op);
  assign accept = (state == MD_IDLE) && start && !flush;

  ex_muldiv_sign_fix #(.WA(XLEN), .WB(XLEN)) u_prep (
    .a(rs1_val), .b(rs2_val), .neg_a(s1), .neg_b(s2), .fix_a(mag1), .fix_b(mag2)
  );

  assign div_zero = op[2] && (rs2_val == '0);
  assign ovf      = ((op == MD_DIV) || (op == MD_REM)) &&
                    (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
  assign fast     = div_zero || ovf;

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    fast_val = '0;
    if (div_zero) fast_val = op[1] ? rs1_val : '1;
    else          fast_val = op[1] ? '0 : rs1_val;
  end

  // acc holds {hi, multiplier} while multiplying and {remainder, quotient} while dividing
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_ge    = div_shift >= {1'b0, m};
    div_sub   = div_shift[XLEN-1:0] - m;
    acc_nxt   = acc;
    if (op_q[2]) begin
      if (div_ge) acc_nxt = {div_sub, acc[XLEN-2:0], 1'b1};
      else        acc_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  assign corr_a = op_q[2] ? {{XLEN{1'b0}}, acc_nxt[XLEN-1:0]} : acc_nxt;

  ex_muldiv_sign_fix #(.WA(2*XLEN), .WB(XLEN)) u_corr (
    .a(corr_a), .b(acc_nxt[2*XLEN-1:XLEN]), .neg_a(neg_q), .neg_b(neg_r),
    .fix_a(fix_a), .fix_b(fix_b)
  );

  always_comb begin
    final_val = fix_a[XLEN-1:0];
    if (op_q[2])               final_val = op_q[1] ? fix_b : fix_a[XLEN-1:0];
    else if (op_q[1:0] != '0)  final_val = fix_a[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (accept) state_nxt = fast ? MD_DONE : MD_BUSY;
      MD_BUSY: begin
        if (flush)                 state_nxt = MD_IDLE;
        else if (cnt == CNT_LAST)  state_nxt = MD_DONE;
      end
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      acc            <= '0;
      m              <= '0;
      op_q           <= MD_MUL;
      neg_q          <= 1'b0;
      neg_r          <= 1'b0;
      rd_q           <= '0;
      result         <= '0;
      result_rd_addr <= '0;
    end else if (accept) begin
      cnt   <= '0;
      op_q  <= op;
      rd_q  <= rd_addr;
      neg_q <= s1 ^ s2;
      neg_r <= s1;
      acc   <= {{XLEN{1'b0}}, (op[2] ? mag1 : mag2)};
      m     <= op[2] ? mag2 : mag1;
      if (fast) begin
        result         <= fast_val;
        result_rd_addr <= rd_addr;
      end
    end else if ((state == MD_BUSY) && !flush) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (cnt == CNT_LAST) begin
        result         <= final_val;
        result_rd_addr <= rd_q;
      end
    end
  end

  assign busy      = (state != MD_IDLE);
  assign done      = (state == MD_DONE);
  assign stall_req = accept || (state == MD_BUSY);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed-vector bench for ex_muldiv: results, latency, flush, async reset.
module tb_ex_muldiv;
  import ex_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_addr;
  logic        stall_req, busy, done;
  logic [31:0] result;
  logic [4:0]  result_rd_addr;

  int checks = 0;
  int errors = 0;

  ex_muldiv #(.XLEN(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1_val(rs1_val),
    .rs2_val(rs2_val), .rd_addr(rd_addr), .flush(flush), .stall_req(stall_req),
    .busy(busy), .done(done), .result(result), .result_rd_addr(result_rd_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // start in cycle 0, count cycles until done; optional stray start in BUSY at cycle glitch
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat, input int glitch);
    int cyc;
    logic stall_drop;
    @(negedge clk);
    op = o; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
    #1 chk({tag, "_stall0"}, {31'b0, stall_req}, 32'd1);
    @(negedge clk);
    start = 1'b0; rs1_val = $urandom; rs2_val = $urandom; rd_addr = 5'd31 - rd;
    cyc = 1;
    stall_drop = 1'b0;
    while (!done && cyc < 60) begin
      if (!stall_req) stall_drop = 1'b1;
      start = (cyc == glitch);
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    chk({tag, "_lat"}, cyc, exp_lat);
    chk({tag, "_stall_held"}, {31'b0, stall_drop}, 32'd0);
    chk({tag, "_res"}, result, exp);
    chk({tag, "_rd"}, {27'b0, result_rd_addr}, {27'b0, rd});
    chk({tag, "_stall_done"}, {31'b0, stall_req}, 32'd0);
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = MD_MUL;
    rs1_val = '0; rs2_val = '0; rd_addr = '0;
    #3;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_stall", {31'b0, stall_req}, 32'd0);
    chk("rst_res", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("mul",    MD_MUL,    32'd7,          32'hFFFFFFFD, 5'd3,  32'hFFFFFFEB, 33, -1);
    run_op("mulh",   MD_MULH,   32'h80000000,   32'h80000000, 5'd4,  32'h40000000, 33, -1);
    run_op("mulhu",  MD_MULHU,  32'hFFFFFFFF,   32'hFFFFFFFF, 5'd5,  32'hFFFFFFFE, 33, -1);
    run_op("mulhsu", MD_MULHSU, 32'hFFFFFFFF,   32'hFFFFFFFF, 5'd6,  32'hFFFFFFFF, 33, -1);
    run_op("div",    MD_DIV,    32'hFFFFFFF9,   32'd2,        5'd7,  32'hFFFFFFFD, 33, -1);
    run_op("rem",    MD_REM,    32'hFFFFFFF9,   32'd2,        5'd8,  32'hFFFFFFFF, 33, -1);
    run_op("divu",   MD_DIVU,   32'd100,        32'd7,        5'd10, 32'd14,       33, -1);
    run_op("remu",   MD_REMU,   32'd100,        32'd7,        5'd11, 32'd2,        33, -1);
    run_op("div0",   MD_DIV,    32'd5,          32'd0,        5'd12, 32'hFFFFFFFF, 1,  -1);
    run_op("remu0",  MD_REMU,   32'd5,          32'd0,        5'd13, 32'd5,        1,  -1);
    run_op("divov",  MD_DIV,    32'h80000000,   32'hFFFFFFFF, 5'd14, 32'h80000000, 1,  -1);
    run_op("remov",  MD_REM,    32'h80000000,   32'hFFFFFFFF, 5'd15, 32'd0,        1,  -1);

    // flush in BUSY cycle 10: no done, previous result (0) kept
    @(negedge clk);
    op = MD_MUL; rs1_val = 32'd3; rs2_val = 32'd4; rd_addr = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_busy", {31'b0, busy}, 32'd0);
    chk("fl_stall", {31'b0, stall_req}, 32'd0);
    chk("fl_done", {31'b0, done}, 32'd0);
    chk("fl_res", result, 32'd0);
    @(negedge clk);
    chk("fl_done2", {31'b0, done}, 32'd0);
    run_op("after_fl", MD_MUL, 32'd3, 32'd4, 5'd9, 32'd12, 33, -1);

    // async reset in BUSY cycle 5
    @(negedge clk);
    op = MD_DIVU; rs1_val = 32'd50; rs2_val = 32'd5; rd_addr = 5'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'b0, busy}, 32'd0);
    chk("ar_stall", {31'b0, stall_req}, 32'd0);
    chk("ar_done", {31'b0, done}, 32'd0);
    chk("ar_res", result, 32'd0);
    chk("ar_rd", {27'b0, result_rd_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst", MD_DIVU, 32'd1000, 32'd10, 5'd21, 32'd100, 33, 5);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      dn += int'(done);
    end
    chk("extra_done", dn, 32'd0);
    chk("held_res", result, 32'd100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
